// File: rtl/dvi_link_sequencer_if.sv
// rtl/dvi_link_sequencer_if.sv - lock, vsync and link-control bundle for the DVI link sequencer
interface dvi_link_sequencer_if #(
  parameter int RELOCK_COUNT_WIDTH = 8
);

  // Inputs to the sequencer (locks are asynchronous to the pixel clock)
  logic                          pll_lock;
  logic                          pll_lock_ser;
  logic                          vsync_in;

  // Registered control outputs of the sequencer
  logic                          ser_reset;
  logic                          source_reset;
  logic                          video_enable;
  logic                          link_up;
  logic [2:0]                    state;
  logic [RELOCK_COUNT_WIDTH-1:0] relock_count;

  // Sequencer side
  modport master (
    input  pll_lock,
    input  pll_lock_ser,
    input  vsync_in,
    output ser_reset,
    output source_reset,
    output video_enable,
    output link_up,
    output state,
    output relock_count
  );

  // Clock-source / observer side
  modport slave (
    output pll_lock,
    output pll_lock_ser,
    output vsync_in,
    input  ser_reset,
    input  source_reset,
    input  video_enable,
    input  link_up,
    input  state,
    input  relock_count
  );

endinterface

// File: rtl/dvi_link_sequencer.sv
// rtl/dvi_link_sequencer.sv - DVI transmit bring-up and lock-loss recovery sequencer
module dvi_link_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SER_RESET_CYCLES   = 16,
  parameter int SOURCE_HOLD_CYCLES = 4,
  parameter int BLANK_FRAMES       = 2,
  parameter int RELOCK_COUNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  dvi_link_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK    = 3'd0,
    ST_LOCK_STABLE  = 3'd1,
    ST_SER_RESET    = 3'd2,
    ST_START_SOURCE = 3'd3,
    ST_BLANK        = 3'd4,
    ST_ACTIVE       = 3'd5
  } state_t;

  // One shared cycle counter serves the three timed states, so it is sized
  // for the longest of them.
  localparam int CNT_MAX_AB = (LOCK_STABLE_CYCLES > SER_RESET_CYCLES) ?
                              LOCK_STABLE_CYCLES : SER_RESET_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_AB > SOURCE_HOLD_CYCLES) ?
                              CNT_MAX_AB : SOURCE_HOLD_CYCLES;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int EDGE_W     = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;

  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SER_LAST    = CNT_W'(SER_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SOURCE_LAST = CNT_W'(SOURCE_HOLD_CYCLES - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST   = EDGE_W'(BLANK_FRAMES);
  localparam logic [RELOCK_COUNT_WIDTH-1:0] RELOCK_MAX = {RELOCK_COUNT_WIDTH{1'b1}};

  // Output bit order: {ser_reset, source_reset, video_enable, link_up}
  function automatic logic [3:0] f_outputs(input state_t s);
    logic [3:0] v;
    v = 4'b1100;
    case (s)
      ST_WAIT_LOCK:    v = 4'b1100;
      ST_LOCK_STABLE:  v = 4'b1100;
      ST_SER_RESET:    v = 4'b1100;
      ST_START_SOURCE: v = 4'b0100;
      ST_BLANK:        v = 4'b0000;
      ST_ACTIVE:       v = 4'b0011;
      default:         v = 4'b1100;
    endcase
    return v;
  endfunction

  logic                          r_lock_pix_s1;
  logic                          r_lock_pix_s2;
  logic                          r_lock_ser_s1;
  logic                          r_lock_ser_s2;
  logic                          r_lock_ok;
  logic                          r_vsync_d;
  logic                          w_vs_edge;

  state_t                        r_state;
  logic [CNT_W-1:0]              r_cnt;
  logic [EDGE_W-1:0]             r_edge_cnt;
  logic [RELOCK_COUNT_WIDTH-1:0] r_relock_count;
  logic                          r_ser_reset;
  logic                          r_source_reset;
  logic                          r_video_enable;
  logic                          r_link_up;

  // Two-flop synchronisers per PLL lock; lock_ok is the registered AND of both,
  // so a lock edge reaches the FSM three clocks after it is first sampled.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lock_pix_s1 <= 1'b0;
      r_lock_pix_s2 <= 1'b0;
      r_lock_ser_s1 <= 1'b0;
      r_lock_ser_s2 <= 1'b0;
      r_lock_ok     <= 1'b0;
    end else begin
      r_lock_pix_s1 <= bus.pll_lock;
      r_lock_pix_s2 <= r_lock_pix_s1;
      r_lock_ser_s1 <= bus.pll_lock_ser;
      r_lock_ser_s2 <= r_lock_ser_s1;
      r_lock_ok     <= r_lock_pix_s2 & r_lock_ser_s2;
    end
  end

  // vsync history is kept in every state so a level already high on BLANK entry is not an edge
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vsync_d <= 1'b0;
    end else begin
      r_vsync_d <= bus.vsync_in;
    end
  end

  assign w_vs_edge = bus.vsync_in & ~r_vsync_d;

  // Bring-up FSM: lock loss outranks every timed or vsync-driven transition;
  // outputs are loaded from the state being entered so they change with the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_WAIT_LOCK;
      r_cnt          <= '0;
      r_edge_cnt     <= '0;
      r_relock_count <= '0;
      {r_ser_reset, r_source_reset, r_video_enable, r_link_up} <= f_outputs(ST_WAIT_LOCK);
    end else if ((r_state != ST_WAIT_LOCK) && !r_lock_ok) begin
      r_state    <= ST_WAIT_LOCK;
      r_cnt      <= '0;
      r_edge_cnt <= '0;
      {r_ser_reset, r_source_reset, r_video_enable, r_link_up} <= f_outputs(ST_WAIT_LOCK);
      if ((r_state == ST_ACTIVE) && (r_relock_count != RELOCK_MAX)) begin
        r_relock_count <= r_relock_count + 1'b1;
      end
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          if (r_lock_ok) begin
            r_state <= ST_LOCK_STABLE;
            r_cnt   <= '0;
            {r_ser_reset, r_source_reset, r_video_enable, r_link_up} <= f_outputs(ST_LOCK_STABLE);
          end
        end
        ST_LOCK_STABLE: begin
          if (r_cnt == STABLE_LAST) begin
            r_state <= ST_SER_RESET;
            r_cnt   <= '0;
            {r_ser_reset, r_source_reset, r_video_enable, r_link_up} <= f_outputs(ST_SER_RESET);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SER_RESET: begin
          if (r_cnt == SER_LAST) begin
            r_state <= ST_START_SOURCE;
            r_cnt   <= '0;
            {r_ser_reset, r_source_reset, r_video_enable, r_link_up} <= f_outputs(ST_START_SOURCE);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_START_SOURCE: begin
          if (r_cnt == SOURCE_LAST) begin
            r_state    <= ST_BLANK;
            r_cnt      <= '0;
            r_edge_cnt <= '0;
            {r_ser_reset, r_source_reset, r_video_enable, r_link_up} <= f_outputs(ST_BLANK);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_BLANK: begin
          // The first edge only marks a frame boundary; BLANK_FRAMES whole
          // frames follow it before video is let through.
          if (w_vs_edge) begin
            if (r_edge_cnt == EDGE_LAST) begin
              r_state    <= ST_ACTIVE;
              r_edge_cnt <= '0;
              {r_ser_reset, r_source_reset, r_video_enable, r_link_up} <= f_outputs(ST_ACTIVE);
            end else begin
              r_edge_cnt <= r_edge_cnt + 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          r_cnt <= '0;
        end
        default: begin
          r_state    <= ST_WAIT_LOCK;
          r_cnt      <= '0;
          r_edge_cnt <= '0;
          {r_ser_reset, r_source_reset, r_video_enable, r_link_up} <= f_outputs(ST_WAIT_LOCK);
        end
      endcase
    end
  end

  assign bus.ser_reset    = r_ser_reset;
  assign bus.source_reset = r_source_reset;
  assign bus.video_enable = r_video_enable;
  assign bus.link_up      = r_link_up;
  assign bus.state        = r_state;
  assign bus.relock_count = r_relock_count;

endmodule

// File: tb/tb_dvi_link_sequencer.sv
// tb/tb_dvi_link_sequencer.sv - directed self-checking bench for dvi_link_sequencer
module tb_dvi_link_sequencer;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  dvi_link_sequencer_if #(.RELOCK_COUNT_WIDTH(2)) bus ();

  dvi_link_sequencer #(
    .LOCK_STABLE_CYCLES (8),
    .SER_RESET_CYCLES   (4),
    .SOURCE_HOLD_CYCLES (4),
    .BLANK_FRAMES       (2),
    .RELOCK_COUNT_WIDTH (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] exp, input int bound, input string tag);
    int n;
    n = 0;
    while (bus.state !== exp && n < bound) begin
      step();
      n++;
    end
    check(tag, bus.state, exp);
  endtask

  task automatic vs_rise();
    bus.vsync_in = 1'b1;
    step();
  endtask

  // Remainder of a 100-cycle vsync period: 4 cycles high in total, 96 low
  task automatic vs_rest();
    repeat (3) step();
    bus.vsync_in = 1'b0;
    repeat (96) step();
  endtask

  task automatic to_active(input string tag);
    wait_state(3'd4, 60, {tag, "_blank"});
    repeat (3) begin
      vs_rise();
      vs_rest();
    end
    check({tag, "_active"}, bus.state, 3'd5);
  endtask

  task automatic lose_lock();
    bus.pll_lock = 1'b0;
    repeat (4) step();
    bus.pll_lock = 1'b1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, bus.state, 3'd0);
    check({tag, "_ser"},   bus.ser_reset, 1'b1);
    check({tag, "_src"},   bus.source_reset, 1'b1);
    check({tag, "_ven"},   bus.video_enable, 1'b0);
    check({tag, "_link"},  bus.link_up, 1'b0);
    check({tag, "_relock"}, bus.relock_count, 2'd0);
  endtask

  int exp_relock [5] = '{1, 2, 3, 3, 3};
  logic seen_ven;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.pll_lock = 1'b0;
    bus.pll_lock_ser = 1'b0;
    bus.vsync_in = 1'b0;
    repeat (3) step();
    check_reset_values("rst");

    // 1. Clean bring-up with exact state timing
    bus.pll_lock = 1'b1;
    bus.pll_lock_ser = 1'b1;
    reset = 1'b0;
    wait_state(3'd1, 10, "t1_enter_stable");
    repeat (7) step();
    check("t1_stable_last", bus.state, 3'd1);
    check("t1_stable_ser", bus.ser_reset, 1'b1);
    step();
    check("t1_ser_state", bus.state, 3'd2);
    repeat (3) step();
    check("t1_ser_hold", bus.ser_reset, 1'b1);
    step();
    check("t1_src_state", bus.state, 3'd3);
    check("t1_ser_fall", bus.ser_reset, 1'b0);
    check("t1_src_high", bus.source_reset, 1'b1);
    repeat (3) step();
    check("t1_src_hold", bus.source_reset, 1'b1);
    step();
    check("t1_blank_state", bus.state, 3'd4);
    check("t1_src_fall", bus.source_reset, 1'b0);
    vs_rise(); vs_rest();
    vs_rise(); vs_rest();
    check("t1_two_edges", bus.state, 3'd4);
    check("t1_ven_low", bus.video_enable, 1'b0);
    vs_rise();
    check("t1_ven_rise", bus.video_enable, 1'b1);
    check("t1_link_up", bus.link_up, 1'b1);
    check("t1_active", bus.state, 3'd5);
    vs_rest();

    // 2. One-cycle serializer lock glitch at stable count 5
    pulse_reset();
    wait_state(3'd1, 10, "t2_enter_stable");
    repeat (4) step();
    bus.pll_lock_ser = 1'b0;
    step();
    bus.pll_lock_ser = 1'b1;
    step();
    step();
    check("t2_still_stable", bus.state, 3'd1);
    step();
    check("t2_back_wait", bus.state, 3'd0);
    step();
    check("t2_restart", bus.state, 3'd1);
    repeat (7) step();
    check("t2_full_count", bus.state, 3'd1);
    step();
    check("t2_ser_state", bus.state, 3'd2);
    check("t2_relock", bus.relock_count, 2'd0);
    to_active("t2");

    // 3. Lock loss in ACTIVE, latency and recovery
    bus.pll_lock = 1'b0;
    repeat (3) step();
    check("t3_lat_hold", bus.link_up, 1'b1);
    step();
    check("t3_state", bus.state, 3'd0);
    check("t3_ser", bus.ser_reset, 1'b1);
    check("t3_src", bus.source_reset, 1'b1);
    check("t3_ven", bus.video_enable, 1'b0);
    check("t3_link", bus.link_up, 1'b0);
    check("t3_relock", bus.relock_count, 2'd1);
    bus.pll_lock = 1'b1;
    to_active("t3_recover");
    check("t3_link_again", bus.link_up, 1'b1);

    // 4. Saturating relock counter, and no count for a loss in BLANK
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      to_active("t4_up");
      lose_lock();
      check("t4_relock", bus.relock_count, exp_relock[i]);
    end
    wait_state(3'd4, 60, "t4_blank");
    lose_lock();
    check("t4_blank_loss_state", bus.state, 3'd0);
    check("t4_blank_loss_count", bus.relock_count, 2'd3);

    // 5a. Lock loss coinciding with the third vsync edge in BLANK
    wait_state(3'd4, 60, "t5_blank");
    vs_rise(); vs_rest();
    vs_rise(); vs_rest();
    bus.pll_lock = 1'b0;
    repeat (3) step();
    check("t5_pre", bus.state, 3'd4);
    bus.vsync_in = 1'b1;
    step();
    check("t5_state", bus.state, 3'd0);
    check("t5_ven", bus.video_enable, 1'b0);
    bus.pll_lock = 1'b1;
    seen_ven = 1'b0;
    repeat (10) begin
      step();
      seen_ven = seen_ven | bus.video_enable;
    end
    check("t5_ven_never", seen_ven, 1'b0);

    // 5b. vsync already high on BLANK entry does not count
    wait_state(3'd4, 60, "t5b_blank");
    repeat (3) step();
    bus.vsync_in = 1'b0;
    repeat (96) step();
    vs_rise(); vs_rest();
    vs_rise(); vs_rest();
    check("t5b_not_yet", bus.state, 3'd4);
    check("t5b_ven_low", bus.video_enable, 1'b0);
    vs_rise();
    check("t5b_active", bus.state, 3'd5);
    check("t5b_ven", bus.video_enable, 1'b1);
    vs_rest();

    // 6. Reset while ACTIVE with relock_count=2
    pulse_reset();
    to_active("t6_a");
    lose_lock();
    to_active("t6_b");
    lose_lock();
    to_active("t6_c");
    check("t6_relock_two", bus.relock_count, 2'd2);
    pulse_reset();
    check_reset_values("t6_rst");
    wait_state(3'd1, 8, "t6_restart");
    check("t6_relock_after", bus.relock_count, 2'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dvi_link_sequencer.md
Name: dvi_link_sequencer

Overview:
Bring-up and recovery controller for the DVI transmit path, clocked in the pixel clock domain. It watches both PLL lock signals and releases the OSER10 serializer reset, then the pattern generator/TMDS encoder reset, in order. It gates video data enable so the encoder sends control-period symbols for a set number of whole frames before active video starts. On any lock loss it drops the link back to a safe reset state and counts the event.

Parameters:
LOCK_STABLE_CYCLES, 1024, consecutive cycles both locks must be high before bring-up continues (>=1)
SER_RESET_CYCLES, 16, cycles ser_reset stays high after locks are stable (>=1)
SOURCE_HOLD_CYCLES, 4, cycles source_reset stays high after ser_reset is released (>=1)
BLANK_FRAMES, 2, whole frames of forced blanking before video_enable (>=0)
RELOCK_COUNT_WIDTH, 8, width of the saturating lock-loss counter

Ports:
clock  in  1  pixel clock
reset  in  1  synchronous, active-high
pll_lock  in  1  pixel PLL lock, asynchronous, synchronised internally
pll_lock_ser  in  1  serializer PLL lock, asynchronous, synchronised internally
vsync_in  in  1  vsync from the timing generator, active high
ser_reset  out  1  OSER10 RESET drive
source_reset  out  1  pattern generator / encoder reset
video_enable  out  1  when 0, the encoder forces de low (control symbols only)
link_up  out  1  high in ACTIVE
state  out  3  current state encoding
relock_count  out  RELOCK_COUNT_WIDTH  lock losses from ACTIVE, saturating

Behaviour:
- Reset values: state=WAIT_LOCK(0), ser_reset=1, source_reset=1, video_enable=0, link_up=0, relock_count=0. Synchroniser flops=0, vsync_d=0, all counters=0.
- Lock synchronisers: each lock input passes through 2 flops. lock_ok = AND of both synchronised locks.
- vsync_d registers vsync_in every cycle in every state. vs_edge = vsync_in & ~vsync_d.
- Outputs are registered Moore outputs, decoded from the next state:
  - WAIT_LOCK(0): ser=1, src=1, ven=0
  - LOCK_STABLE(1): ser=1, src=1, ven=0
  - SER_RESET(2): ser=1, src=1, ven=0
  - START_SOURCE(3): ser=0, src=1, ven=0
  - BLANK(4): ser=0, src=0, ven=0
  - ACTIVE(5): ser=0, src=0, ven=1, link_up=1
- Transitions:
  - WAIT_LOCK -> LOCK_STABLE when lock_ok. The stable counter clears.
  - LOCK_STABLE stays exactly LOCK_STABLE_CYCLES cycles with lock_ok high, then -> SER_RESET.
  - SER_RESET stays SER_RESET_CYCLES cycles, then -> START_SOURCE.
  - START_SOURCE stays SOURCE_HOLD_CYCLES cycles, then -> BLANK. The edge counter clears on entry.
  - BLANK -> ACTIVE on the (BLANK_FRAMES+1)th vs_edge seen while in BLANK. With BLANK_FRAMES=0 this is the first edge. video_enable rises the cycle after that edge.
  - ACTIVE stays until lock loss or reset.
- Lock loss: lock_ok=0 in any state other than WAIT_LOCK -> WAIT_LOCK on the next edge. Counters clear.
  - Latency: a pll input falling before edge t is seen as lock_ok=0 at t+2, and the outputs show reset values after edge t+3.
  - relock_count increments only when the loss occurs from ACTIVE. It saturates at all-ones.
- Priority: reset > lock loss > vs_edge/counter expiry.
  - A vs_edge in the same cycle as lock loss is ignored.
  - If vsync_in is already high when BLANK is entered, that is not an edge.
- Mid-operation reset returns to reset values on the next edge, including relock_count=0.
- A lock_ok glitch of any length, even 1 cycle, during LOCK_STABLE restarts the full stable count from WAIT_LOCK.
- state encoding is fixed as listed; codes 6 and 7 are unreachable and map to WAIT_LOCK.

Test Plan:
All scenarios use LOCK_STABLE_CYCLES=8, SER_RESET_CYCLES=4, SOURCE_HOLD_CYCLES=4, BLANK_FRAMES=2, vsync period 100 cycles.
1. Clean bring-up: reset released, both locks high.
   -> state 1 for 8 cycles, ser_reset falls 12 cycles after entering state 1, source_reset falls 4 cycles later.
   -> video_enable=1 and link_up=1 one cycle after the 3rd vsync rising edge in BLANK.
2. Glitch during stable count: pll_lock_ser low for 1 cycle at stable count 5.
   -> state returns to 0, then a full 8-cycle state 1 before state 2; relock_count stays 0.
3. Lock loss in ACTIVE: pll_lock falls.
   -> 3 edges later ser_reset=1, source_reset=1, video_enable=0, link_up=0, relock_count=1.
   -> Restore lock -> ACTIVE is reached again via the full sequence.
4. Counter saturation: RELOCK_COUNT_WIDTH=2, five lock losses from ACTIVE.
   -> relock_count reads 1,2,3,3,3.
   -> One lock loss in BLANK leaves the count unchanged.
5. Simultaneous events in BLANK: lock loss and the 3rd vs_edge in the same cycle.
   -> state=WAIT_LOCK, video_enable never rises.
   -> Separately, vsync_in held high across BLANK entry is not counted; ACTIVE needs 3 fresh rising edges.
6. Reset in ACTIVE with relock_count=2: assert reset for 1 cycle.
   -> next edge gives all outputs at reset values, relock_count=0.
   -> With locks still high, the sequence restarts after 2 synchroniser cycles.
